// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared types for the L1 dcache and its coherence logic.
//
// Contents:
//   DC_IDX_W, DC_TAG_W, DC_WAYS  dcache geometry (8 sets, 2 ways, 2-word blocks)
//   snoop_state_t                snoop responder FSM state
//   dcache_addr_t                byte address split into tag/idx/blkoff/bytoff
//   sat_inc16                    16-bit saturating increment
package cpu_types_pkg;

  localparam int DC_IDX_W = 3;
  localparam int DC_TAG_W = 32 - DC_IDX_W - 1 - 2;
  localparam int DC_WAYS  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB0  = 2'd1,
    WB1  = 2'd2,
    DONE = 2'd3
  } snoop_state_t;

  typedef struct packed {
    logic [DC_TAG_W-1:0] tag;
    logic [DC_IDX_W-1:0] idx;
    logic                blkoff;
    logic [1:0]          bytoff;
  } dcache_addr_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/dcache_snoop_responder.sv
// dcache_snoop_responder -- cache-side responder to the coherence bus controller.
//
// Looks up the snooped block in the dcache frame array. A Modified hit raises
// ccwrite in the snoop cycle and flushes the two-word block (one word per dwait
// handshake) while owning the cache's bus outputs. Clean hits are invalidated
// on request; the dirty block is invalidated after its flush if ccinv was seen.
//
// Ports:
//   CLK, nRST                  clock, asynchronous active-low reset
//   ccwait, ccinv, ccsnoopaddr snoop request from the bus controller
//   dwait                      bus word handshake (low = word accepted)
//   ccwrite                    this cache supplies the snooped block
//   snp_active                 responder owns daddr/dstore/dWEN
//   snp_dWEN, snp_daddr, snp_dstore  write-back word
//   lk_idx                     frame-array read index (combinational)
//   lk_valid, lk_dirty, lk_tag, lk_data  per-way frame contents at lk_idx
//   upd_en, upd_way, upd_idx, upd_clr_valid, upd_clr_dirty  frame-state update
//   stat_hits, stat_wbs, stat_invs  saturating counters (SNOOP_STATS_EN only)
//
// Build option: define SNOOP_STATS_EN to add the statistics counters.
module dcache_snoop_responder
  import cpu_types_pkg::*;
#(
  parameter  int IDX_W = DC_IDX_W,
  parameter  int TAG_W = DC_TAG_W,
  parameter  int WAYS  = DC_WAYS,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   ccwait,
  input  logic                   ccinv,
  input  logic [31:0]            ccsnoopaddr,
  input  logic                   dwait,
  output logic                   ccwrite,
  output logic                   snp_active,
  output logic                   snp_dWEN,
  output logic [31:0]            snp_daddr,
  output logic [31:0]            snp_dstore,
  output logic [IDX_W-1:0]       lk_idx,
  input  logic [WAYS-1:0]        lk_valid,
  input  logic [WAYS-1:0]        lk_dirty,
  input  logic [WAYS*TAG_W-1:0]  lk_tag,
  input  logic [WAYS*64-1:0]     lk_data,
  output logic                   upd_en,
  output logic [WAY_W-1:0]       upd_way,
  output logic [IDX_W-1:0]       upd_idx,
  output logic                   upd_clr_valid,
  output logic                   upd_clr_dirty
`ifdef SNOOP_STATS_EN
  ,
  output logic [15:0]            stat_hits,
  output logic [15:0]            stat_wbs,
  output logic [15:0]            stat_invs
`endif
);

  snoop_state_t state;

  logic [TAG_W-1:0] snp_tag;
  logic [IDX_W-1:0] snp_idx;
  logic             unused_addr_bits;

  assign snp_tag          = ccsnoopaddr[31 -: TAG_W];
  assign snp_idx          = ccsnoopaddr[IDX_W+2:3];
  assign unused_addr_bits = ^ccsnoopaddr[2:0];

  // Latched copy of the block being flushed; the snoop address may change.
  logic [WAY_W-1:0] lat_way;
  logic [IDX_W-1:0] lat_idx;
  logic [TAG_W-1:0] lat_tag;
  logic [31:0]      lat_w0, lat_w1;
  logic             inv_pend;

  // During a flush the frame array must keep presenting the latched set.
  assign lk_idx = (state == IDLE) ? snp_idx : lat_idx;

  // Tag compare across all ways; scanning downwards lets the lowest match win.
  logic             hit;
  logic             hit_dirty;
  logic [WAY_W-1:0] hit_way;
  logic [31:0]      hit_w0, hit_w1;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; that is what keeps latches from being inferred.
    hit     = 1'b0;
    hit_way = '0;
    hit_w0  = '0;
    hit_w1  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lk_valid[w] && (lk_tag[w*TAG_W +: TAG_W] == snp_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
        hit_w0  = lk_data[w*64 +: 32];
        hit_w1  = lk_data[w*64 + 32 +: 32];
      end
    end
  end

  assign hit_dirty = hit & lk_dirty[hit_way];

  logic snoop_dirty, snoop_clean_inv;
  assign snoop_dirty     = ccwait & hit_dirty;
  assign snoop_clean_inv = ccwait & ccinv & hit & ~hit_dirty;

  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!nRST) begin
      state    <= IDLE;
      lat_way  <= '0;
      lat_idx  <= '0;
      lat_tag  <= '0;
      lat_w0   <= '0;
      lat_w1   <= '0;
      inv_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (snoop_dirty) begin
            lat_way  <= hit_way;
            lat_idx  <= snp_idx;
            lat_tag  <= snp_tag;
            lat_w0   <= hit_w0;
            lat_w1   <= hit_w1;
            inv_pend <= ccinv;
            state    <= WB0;
          end
        end
        WB0: begin
          // Dropping ccwait abandons the flush; the block simply stays dirty.
          if (!ccwait) begin
            state <= IDLE;
          end else begin
            inv_pend <= inv_pend | ccinv;
            if (!dwait) state <= WB1;
          end
        end
        WB1: begin
          if (!ccwait) begin
            state <= IDLE;
          end else begin
            inv_pend <= inv_pend | ccinv;
            if (!dwait) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ccwrite       = 1'b0;
    snp_active    = 1'b0;
    snp_dWEN      = 1'b0;
    snp_daddr     = '0;
    snp_dstore    = '0;
    upd_en        = 1'b0;
    upd_way       = '0;
    upd_idx       = '0;
    upd_clr_valid = 1'b0;
    upd_clr_dirty = 1'b0;
    // The IDLE outputs are combinational from the bus, so they are gated by
    // reset to keep every output low while nRST is asserted.
    if (nRST) begin
      case (state)
        IDLE: begin
          ccwrite = snoop_dirty;
          if (snoop_clean_inv) begin
            upd_en        = 1'b1;
            upd_way       = hit_way;
            upd_idx       = snp_idx;
            upd_clr_valid = 1'b1;
          end
        end
        WB0, WB1: begin
          ccwrite    = 1'b1;
          snp_active = 1'b1;
          snp_dWEN   = 1'b1;
          snp_daddr  = 32'({lat_tag, lat_idx, (state == WB1), 2'b00});
          snp_dstore = (state == WB1) ? lat_w1 : lat_w0;
        end
        DONE: begin
          upd_en        = 1'b1;
          upd_way       = lat_way;
          upd_idx       = lat_idx;
          upd_clr_dirty = 1'b1;
          upd_clr_valid = inv_pend;
        end
        default: ;
      endcase
    end
  end

`ifdef SNOOP_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_hits <= '0;
      stat_wbs  <= '0;
      stat_invs <= '0;
    end else begin
      stat_hits <= sat_inc16(stat_hits, (state == IDLE) && ccwait && hit);
      stat_wbs  <= sat_inc16(stat_wbs, state == DONE);
      stat_invs <= sat_inc16(stat_invs,
                             ((state == IDLE) && snoop_clean_inv) ||
                             ((state == DONE) && inv_pend));
    end
  end
`endif

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// tb_dcache_snoop_responder -- self-checking bench for dcache_snoop_responder.
// Emulates the frame array the responder looks up, drives snoops as whole
// transactions, and predicts every output from a set/way model of the cache.
module tb_dcache_snoop_responder;
  import cpu_types_pkg::*;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         ccwait, ccinv, dwait;
  logic [31:0]  ccsnoopaddr;
  logic         ccwrite, snp_active, snp_dWEN;
  logic [31:0]  snp_daddr, snp_dstore;
  logic [2:0]   lk_idx;
  logic [1:0]   lk_valid, lk_dirty;
  logic [51:0]  lk_tag;
  logic [127:0] lk_data;
  logic         upd_en, upd_clr_valid, upd_clr_dirty;
  logic [0:0]   upd_way;
  logic [2:0]   upd_idx;
`ifdef SNOOP_STATS_EN
  logic [15:0]  stat_hits, stat_wbs, stat_invs;
`endif

  dcache_snoop_responder dut (
    .CLK(CLK), .nRST(nRST),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .dwait(dwait),
    .ccwrite(ccwrite), .snp_active(snp_active), .snp_dWEN(snp_dWEN),
    .snp_daddr(snp_daddr), .snp_dstore(snp_dstore),
    .lk_idx(lk_idx), .lk_valid(lk_valid), .lk_dirty(lk_dirty),
    .lk_tag(lk_tag), .lk_data(lk_data),
    .upd_en(upd_en), .upd_way(upd_way), .upd_idx(upd_idx),
    .upd_clr_valid(upd_clr_valid), .upd_clr_dirty(upd_clr_dirty)
`ifdef SNOOP_STATS_EN
    , .stat_hits(stat_hits), .stat_wbs(stat_wbs), .stat_invs(stat_invs)
`endif
  );

  always #5 CLK = ~CLK;

  // Frame array as the cache holds it (f_*), updated from the DUT's strobes,
  // and the bench's own expectation of it (m_*).
  logic        f_valid [8][2];
  logic        f_dirty [8][2];
  logic [25:0] f_tag   [8][2];
  logic [31:0] f_data  [8][2][2];
  logic        m_valid [8][2];
  logic        m_dirty [8][2];
  logic [25:0] m_tag   [8][2];
  logic [31:0] m_data  [8][2][2];

  always_comb begin
    lk_valid = '0;
    lk_dirty = '0;
    lk_tag   = '0;
    lk_data  = '0;
    for (int w = 0; w < 2; w++) begin
      lk_valid[w]               = f_valid[lk_idx][w];
      lk_dirty[w]               = f_dirty[lk_idx][w];
      lk_tag[w*26 +: 26]        = f_tag[lk_idx][w];
      lk_data[w*64 +: 32]       = f_data[lk_idx][w][0];
      lk_data[w*64 + 32 +: 32]  = f_data[lk_idx][w][1];
    end
  end

  int checks = 0;
  int failures = 0;
  int exp_hits = 0, exp_wbs = 0, exp_invs = 0;

  logic       p_en, p_cv, p_cd;
  logic [0:0] p_way;
  logic [2:0] p_idx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // The cache applies a strobe seen in the previous cycle.
  task automatic apply_pending();
    if (p_en) begin
      if (p_cv) f_valid[p_idx][p_way] = 1'b0;
      if (p_cd) f_dirty[p_idx][p_way] = 1'b0;
    end
    p_en = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, sample 1 ns later.
  task automatic step(input logic cw, input logic inv, input logic dw, input logic [31:0] a);
    @(negedge CLK);
    apply_pending();
    ccwait = cw; ccinv = inv; dwait = dw; ccsnoopaddr = a;
    #1;
    p_en = upd_en; p_cv = upd_clr_valid; p_cd = upd_clr_dirty;
    p_way = upd_way; p_idx = upd_idx;
  endtask

  task automatic set_frame(input int i, input int w, input logic v, input logic dty,
                           input logic [25:0] t, input logic [31:0] d0, input logic [31:0] d1);
    apply_pending();
    f_valid[i][w] = v;   m_valid[i][w] = v;
    f_dirty[i][w] = dty; m_dirty[i][w] = dty;
    f_tag[i][w]   = t;   m_tag[i][w]   = t;
    f_data[i][w][0] = d0; m_data[i][w][0] = d0;
    f_data[i][w][1] = d1; m_data[i][w][1] = d1;
  endtask

  task automatic compare_frames();
    for (int i = 0; i < 8; i++)
      for (int w = 0; w < 2; w++) begin
        check("frame_valid", f_valid[i][w], m_valid[i][w]);
        check("frame_dirty", f_dirty[i][w], m_dirty[i][w]);
      end
  endtask

  // A full snoop transaction. n0/n1: dwait-high cycles per word.
  // inv_mode: 0 no ccinv during flush, 1 ccinv throughout word1, 2 random.
  // abort_at: flush cycle at which ccwait drops (-1 = never).
  task automatic do_snoop(input logic [31:0] a, input logic inv0, input int n0, input int n1,
                          input int inv_mode, input int abort_at);
    dcache_addr_t d;
    int          hw, cyc, n;
    logic        hit, dirty, inv_acc, civ;
    logic [31:0] base;
    d = a; hit = 1'b0; hw = 0;
    for (int w = 0; w < 2; w++)
      if (!hit && m_valid[d.idx][w] && m_tag[d.idx][w] == d.tag) begin
        hit = 1'b1; hw = w;
      end
    dirty = hit && m_dirty[d.idx][hw];
    if (hit) exp_hits++;
    step(1'b1, inv0, 1'b1, a);
    check("snoop_ccwrite", ccwrite, dirty);
    check("snoop_active", snp_active, 0);
    if (!dirty) begin
      check("snoop_upd_en", upd_en, hit & inv0);
      if (hit && inv0) begin
        check("inv_clr_valid", upd_clr_valid, 1);
        check("inv_clr_dirty", upd_clr_dirty, 0);
        check("inv_idx", upd_idx, d.idx);
        check("inv_way", upd_way, hw);
        m_valid[d.idx][hw] = 1'b0;
        exp_invs++;
      end
      return;
    end
    check("snoop_upd_en", upd_en, 0);
    inv_acc = inv0;
    base = {d.tag, d.idx, 3'b000};
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? n0 : n1;
      for (int j = 0; j <= n; j++) begin
        if (cyc == abort_at) begin
          step(1'b0, 1'b0, 1'b1, $urandom);
          check("abort_cycle_active", snp_active, 1);
          check("abort_cycle_upd", upd_en, 0);
          step(1'b0, 1'b0, 1'b1, $urandom);
          check("abort_active", snp_active, 0);
          check("abort_dwen", snp_dWEN, 0);
          check("abort_ccwrite", ccwrite, 0);
          check("abort_upd", upd_en, 0);
          return;
        end
        civ = (inv_mode == 1 && k == 1) || (inv_mode == 2 && $urandom_range(0, 3) == 0);
        inv_acc |= civ;
        step(1'b1, civ, (j == n) ? 1'b0 : 1'b1, $urandom);
        check("wb_active", snp_active, 1);
        check("wb_dwen", snp_dWEN, 1);
        check("wb_ccwrite", ccwrite, 1);
        check("wb_daddr", snp_daddr, base + 32'(4 * k));
        check("wb_dstore", snp_dstore, m_data[d.idx][hw][k]);
        check("wb_upd", upd_en, 0);
        cyc++;
      end
    end
    step(1'b0, 1'b0, 1'b1, $urandom);
    check("done_active", snp_active, 0);
    check("done_ccwrite", ccwrite, 0);
    check("done_dwen", snp_dWEN, 0);
    check("done_upd_en", upd_en, 1);
    check("done_way", upd_way, hw);
    check("done_idx", upd_idx, d.idx);
    check("done_clr_dirty", upd_clr_dirty, 1);
    check("done_clr_valid", upd_clr_valid, inv_acc);
    m_dirty[d.idx][hw] = 1'b0;
    if (inv_acc) m_valid[d.idx][hw] = 1'b0;
    exp_wbs++;
    if (inv_acc) exp_invs++;
  endtask

  task automatic idle_check(input string tag);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    check({tag, "_active"}, snp_active, 0);
    check({tag, "_upd"}, upd_en, 0);
  endtask

  initial begin
    logic [31:0] a;
    nRST = 1'b0; ccwait = 1'b0; ccinv = 1'b0; dwait = 1'b1; ccsnoopaddr = '0;
    p_en = 1'b0; p_cv = 1'b0; p_cd = 1'b0; p_way = '0; p_idx = '0;
    for (int i = 0; i < 8; i++)
      for (int w = 0; w < 2; w++) set_frame(i, w, 1'b0, 1'b0, '0, '0, '0);
    #2;
    check("rst_ccwrite", ccwrite, 0);
    check("rst_active", snp_active, 0);
    check("rst_dwen", snp_dWEN, 0);
    check("rst_daddr", snp_daddr, 0);
    check("rst_dstore", snp_dstore, 0);
    check("rst_upd_en", upd_en, 0);
    @(negedge CLK); @(negedge CLK);
    nRST = 1'b1;

    // Set 2: way0 clean, way1 Modified; block bases 0x210 (tag 8) and 0x250 (tag 9).
    set_frame(2, 0, 1'b1, 1'b0, 26'd8, 32'h11111111, 32'h22222222);
    set_frame(2, 1, 1'b1, 1'b1, 26'd9, 32'hDEADBEEF, 32'hCAFEF00D);
    do_snoop(32'h0000_0210, 1'b0, 0, 0, 0, -1);          // clean hit, no inv
    idle_check("clean_stay_idle");
    do_snoop(32'h0000_0250, 1'b0, 1, 1, 0, -1);          // Modified flush
    idle_check("after_flush");
    set_frame(2, 1, 1'b1, 1'b1, 26'd9, 32'hDEADBEEF, 32'hCAFEF00D);
    do_snoop(32'h0000_0254, 1'b0, 0, 2, 1, -1);          // ccinv during WB1
    idle_check("after_inv_flush");
    do_snoop(32'h0000_0210, 1'b1, 0, 0, 0, -1);          // clean hit invalidate
    idle_check("after_clean_inv");
    compare_frames();

    // Abort in WB0, then the same block flushes again with unchanged data.
    set_frame(3, 0, 1'b1, 1'b1, 26'h2A5, 32'h0BADF00D, 32'h12345678);
    do_snoop({26'h2A5, 3'd3, 3'b000}, 1'b0, 2, 0, 0, 1);
    idle_check("after_abort");
    do_snoop({26'h2A5, 3'd3, 3'b100}, 1'b0, 0, 0, 0, -1);
    idle_check("after_reflush");

    // Asynchronous reset in WB1: outputs drop at once, no strobe.
    set_frame(4, 1, 1'b1, 1'b1, 26'h155, 32'hA5A5A5A5, 32'h5A5A5A5A);
    a = {26'h155, 3'd4, 3'b000};
    step(1'b1, 1'b0, 1'b1, a);
    check("pre_rst_ccwrite", ccwrite, 1);
    step(1'b1, 1'b0, 1'b0, $urandom);
    step(1'b1, 1'b0, 1'b1, $urandom);
    check("pre_rst_wb1_addr", snp_daddr, a + 32'd4);
    #2 nRST = 1'b0;
    #1;
    check("midrst_ccwrite", ccwrite, 0);
    check("midrst_active", snp_active, 0);
    check("midrst_dwen", snp_dWEN, 0);
    check("midrst_daddr", snp_daddr, 0);
    check("midrst_dstore", snp_dstore, 0);
    check("midrst_upd", upd_en, 0);
    p_en = 1'b0;
    exp_hits = 0; exp_wbs = 0; exp_invs = 0;
    @(negedge CLK);
    nRST = 1'b1;
    do_snoop(32'h0000_0F00, 1'b0, 0, 0, 0, -1);          // miss
    idle_check("after_miss");
    do_snoop(a, 1'b0, 0, 1, 0, -1);                      // block survived reset dirty
    idle_check("after_rst_reflush");
    compare_frames();

    // Randomized traffic over a small tag pool so hits are frequent.
    for (int i = 0; i < 8; i++)
      for (int w = 0; w < 2; w++) begin
        logic v;
        v = 1'($urandom_range(0, 1));
        set_frame(i, w, v, v & 1'($urandom_range(0, 1)), 26'(8 + $urandom_range(0, 3)),
                  $urandom, $urandom);
      end
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        logic v;
        v = 1'($urandom_range(0, 3) != 0);
        set_frame($urandom_range(0, 7), $urandom_range(0, 1), v,
                  v & 1'($urandom_range(0, 1)), 26'(8 + $urandom_range(0, 3)),
                  $urandom, $urandom);
      end
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = {26'(8 + $urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
      do_snoop(a, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), 2,
               ($urandom_range(0, 4) == 0) ? $urandom_range(0, 5) : -1);
      idle_check("rand_idle");
      if (t % 50 == 49) compare_frames();
    end
    step(1'b0, 1'b0, 1'b1, 32'h0);
    compare_frames();

`ifdef SNOOP_STATS_EN
    check("stat_hits", stat_hits, exp_hits);
    check("stat_wbs", stat_wbs, exp_wbs);
    check("stat_invs", stat_invs, exp_invs);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
